// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer.
// Holds default geometry, statistics counter width/limit and channel ids.
package demux_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 2;

   localparam int               STAT_W   = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

endpackage

// File: rtl/sync_fifo_buf.sv
// Small synchronous FIFO, registered head output, no bypass.
// Ports: clk, rst (async high), push/din, pop, dout (head), full, empty.
module sync_fifo_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Power-of-2 depth: pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux2x32_buf.sv
// Buffered 1-to-2 demux: steers A to FIFO[S]; each channel has valid/ready.
// Ports: CLK, RST, A, S, VI, RI, Y0/V0/R0, Y1/V1/R1; C0/C1 with DEMUX2X32_STATS_EN.
module demux2x32_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A,
   input  logic             S,
   input  logic             VI,
   output logic             RI,
   output logic [WIDTH-1:0] Y0,
   output logic             V0,
   input  logic             R0,
   output logic [WIDTH-1:0] Y1,
   output logic             V1,
   input  logic             R1
`ifdef DEMUX2X32_STATS_EN
   ,
   output logic [STAT_W-1:0] C0,
   output logic [STAT_W-1:0] C1
`endif
);

   logic full0;
   logic full1;
   logic empty0;
   logic empty1;
   logic push0;
   logic push1;

   // Ready reflects only the addressed channel, never VI.
   assign RI    = (S == CH1) ? ~full1 : ~full0;
   assign push0 = VI & RI & (S == CH0);
   assign push1 = VI & RI & (S == CH1);
   assign V0    = ~empty0;
   assign V1    = ~empty1;

   sync_fifo_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo0 (
      .clk   (CLK),
      .rst   (RST),
      .push  (push0),
      .din   (A),
      .pop   (R0),
      .dout  (Y0),
      .full  (full0),
      .empty (empty0)
   );

   sync_fifo_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo1 (
      .clk   (CLK),
      .rst   (RST),
      .push  (push1),
      .din   (A),
      .pop   (R1),
      .dout  (Y1),
      .full  (full1),
      .empty (empty1)
   );

`ifdef DEMUX2X32_STATS_EN
   logic [STAT_W-1:0] cnt0;
   logic [STAT_W-1:0] cnt1;

   // Accept counters, saturating.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (push0 && cnt0 != STAT_MAX) begin
            cnt0 <= cnt0 + 1'b1;
         end
         if (push1 && cnt1 != STAT_MAX) begin
            cnt1 <= cnt1 + 1'b1;
         end
      end
   end

   assign C0 = cnt0;
   assign C1 = cnt1;
`endif

endmodule

// File: tb/tb_demux2x32_buf.sv
// Directed self-checking bench for demux2x32_buf (default WIDTH=32, DEPTH=2).
// Inputs change 1 time unit after each rising edge; outputs checked mid-cycle.
module tb_demux2x32_buf;

   logic        CLK;
   logic        RST;
   logic [31:0] A;
   logic        S;
   logic        VI;
   logic        RI;
   logic [31:0] Y0;
   logic        V0;
   logic        R0;
   logic [31:0] Y1;
   logic        V1;
   logic        R1;
`ifdef DEMUX2X32_STATS_EN
   logic [15:0] C0;
   logic [15:0] C1;
`endif

   int checks;
   int fails;

   demux2x32_buf dut (
      .CLK (CLK),
      .RST (RST),
      .A   (A),
      .S   (S),
      .VI  (VI),
      .RI  (RI),
      .Y0  (Y0),
      .V0  (V0),
      .R0  (R0),
      .Y1  (Y1),
      .V1  (V1),
      .R1  (R1)
`ifdef DEMUX2X32_STATS_EN
      ,
      .C0  (C0),
      .C1  (C1)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin : main
      logic [31:0] got [$];
      int          sent;
      int          cyc;

      checks = 0;
      fails  = 0;
      RST = 1'b1;
      VI  = 1'b1;
      S   = 1'b0;
      A   = 32'hAAAA_AAAA;
      R0  = 1'b0;
      R1  = 1'b0;

      // Reset held two cycles with VI=1: nothing accepted
      step();
      step();
      check("rst_v0", {31'd0, V0}, 32'd0);
      check("rst_v1", {31'd0, V1}, 32'd0);
      check("rst_y0", Y0, 32'd0);
      check("rst_y1", Y1, 32'd0);
      check("rst_ri", {31'd0, RI}, 32'd1);
      RST = 1'b0;
      VI  = 1'b0;
      step();
      check("idle_v0", {31'd0, V0}, 32'd0);

      // Single steer to channel 0
      VI = 1'b1; S = 1'b0; A = 32'h1234_5678;
      step();
      VI = 1'b0;
      check("st0_v0", {31'd0, V0}, 32'd1);
      check("st0_y0", Y0, 32'h1234_5678);
      check("st0_v1", {31'd0, V1}, 32'd0);

      // Single steer to channel 1
      VI = 1'b1; S = 1'b1; A = 32'hDEAD_BEEF;
      step();
      VI = 1'b0;
      check("st1_v1", {31'd0, V1}, 32'd1);
      check("st1_y1", Y1, 32'hDEAD_BEEF);

      // Drain channel 1
      R1 = 1'b1;
      step();
      R1 = 1'b0;
      check("drain1_v1", {31'd0, V1}, 32'd0);

      // Fill channel 0 with a second word
      VI = 1'b1; S = 1'b0; A = 32'h0000_0011;
      #1;
      check("fill0_ri_pre", {31'd0, RI}, 32'd1);
      step();
      check("full0_ri", {31'd0, RI}, 32'd0);
      step();
      check("full0_hold_y0", Y0, 32'h1234_5678);

      // Other channel still accepts
      S = 1'b1; A = 32'h0000_0005;
      #1;
      check("indep_ri", {31'd0, RI}, 32'd1);
      step();
      VI = 1'b0;
      check("indep_v1", {31'd0, V1}, 32'd1);
      check("indep_y1", Y1, 32'h0000_0005);

      // Full channel 0 with pop and push attempt in same cycle
      VI = 1'b1; S = 1'b0; A = 32'h0000_0022; R0 = 1'b1;
      #1;
      check("fullpop_ri", {31'd0, RI}, 32'd0);
      step();
      R0 = 1'b0;
      check("fullpop_y0", Y0, 32'h0000_0011);
      check("fullpop_ri_rec", {31'd0, RI}, 32'd1);
      step();
      VI = 1'b0;
      check("fullpop_push_y0", Y0, 32'h0000_0011);
      check("fullpop_push_ri", {31'd0, RI}, 32'd0);
      R0 = 1'b1;
      step();
      check("drain0_y0", Y0, 32'h0000_0022);
      step();
      R0 = 1'b0;
      check("drain0_v0", {31'd0, V0}, 32'd0);

      // Drain channel 1 (holds 5)
      R1 = 1'b1;
      step();
      R1 = 1'b0;
      check("drain1b_v1", {31'd0, V1}, 32'd0);

      // Ordering and wrap: 1..5 into channel 1 with R1 toggling
      sent = 0;
      cyc  = 0;
      S    = 1'b1;
      while (got.size() < 5 && cyc < 40) begin
         VI = (sent < 5);
         A  = sent + 1;
         R1 = cyc[0];
         #3;
         if (V1 && R1) got.push_back(Y1);
         if (VI && RI) sent++;
         step();
         cyc++;
      end
      VI = 1'b0;
      R1 = 1'b0;
      check("ord_count", got.size(), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) check($sformatf("ord_%0d", i), got[i], i + 1);
      end

      // Load both channels then pulse reset between edges
      VI = 1'b1; S = 1'b0; A = 32'h0000_0077;
      step();
      S = 1'b1; A = 32'h0000_0088;
      step();
      VI = 1'b0;
      check("pre_rst_v0", {31'd0, V0}, 32'd1);
      check("pre_rst_v1", {31'd0, V1}, 32'd1);
      #2;
      RST = 1'b1;
      #1;
      check("arst_v0", {31'd0, V0}, 32'd0);
      check("arst_v1", {31'd0, V1}, 32'd0);
      check("arst_y0", Y0, 32'd0);
      check("arst_y1", Y1, 32'd0);
      #1;
      RST = 1'b0;
`ifdef DEMUX2X32_STATS_EN
      check("arst_c0", {16'd0, C0}, 32'd0);
      check("arst_c1", {16'd0, C1}, 32'd0);
`endif

      // Three accepts to channel 0 with consumer ready
      step();
      VI = 1'b1; S = 1'b0; R0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A = 32'h100 + i;
         step();
      end
      VI = 1'b0;
      R0 = 1'b0;
      check("post_y0", Y0, 32'h0000_0102);
      check("post_v0", {31'd0, V0}, 32'd1);
`ifdef DEMUX2X32_STATS_EN
      check("stat_c0", {16'd0, C0}, 32'd3);
      check("stat_c1", {16'd0, C1}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
